vga_timing_ctrl: RTL

- Sequences the VGA pixel datapath for the maze display.
- Generates the pixel-rate enable from the system clock, plus the horizontal and vertical counters, hsync/vsync and the active-video window.
- Provides line-end and frame-end strobes that the renderer and game logic use to align updates.
- Runs entirely in the system clock domain; the pixel rate is a one-cycle enable, not a derived clock.

---
 rtl/vga_timing_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: pixel-rate enable, h/v counters, sync pulses, active window
// and line/frame strobes, all in the system clock domain with registered outputs.
module vga_timing_ctrl #(
  parameter int   DIV      = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_end,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [9:0]  H_LAST        = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST        = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_FRONT_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BACK_START  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END     = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (DIV < 1)) begin : g_bad_cfg
    $error("vga_timing_ctrl: totals must be <= 1024 and DIV >= 1");
  end

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;

  // Horizontal phase is derived from the count so the two can never disagree.
  function automatic h_state_t h_decode(input logic [9:0] cnt);
    logic [10:0] c;
    c = {1'b0, cnt};
    if (c < H_FRONT_START)     h_decode = H_ACT;
    else if (c < H_SYNC_START) h_decode = H_FRONT;
    else if (c < H_BACK_START) h_decode = H_SYNCP;
    else                       h_decode = H_BACK;
  endfunction

  logic [DIV_W-1:0] div_cnt_r, div_next_s;
  logic [9:0]       h_cnt_r, h_next_s;
  logic [9:0]       v_cnt_r, v_next_s;
  h_state_t         h_state_r, h_state_next_s;
  logic             tick_s, line_wrap_s, frame_wrap_s;
  logic             hsync_s, vsync_s, video_s;

  // State register: divider, counters and horizontal phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= {DIV_W{1'b0}};
      h_cnt_r   <= 10'd0;
      v_cnt_r   <= 10'd0;
      h_state_r <= H_ACT;
    end else begin
      div_cnt_r <= div_next_s;
      h_cnt_r   <= h_next_s;
      v_cnt_r   <= v_next_s;
      h_state_r <= h_state_next_s;
    end
  end

  // Next-state logic: pixel tick, line wrap and frame wrap.
  always_comb begin
    tick_s       = enable && (div_cnt_r == DIV_LAST);
    line_wrap_s  = tick_s && (h_cnt_r == H_LAST);
    frame_wrap_s = line_wrap_s && (v_cnt_r == V_LAST);

    if (!enable)     div_next_s = div_cnt_r;
    else if (tick_s) div_next_s = {DIV_W{1'b0}};
    else             div_next_s = div_cnt_r + DIV_W'(1);

    if (line_wrap_s) h_next_s = 10'd0;
    else if (tick_s) h_next_s = h_cnt_r + 10'd1;
    else             h_next_s = h_cnt_r;

    if (frame_wrap_s)     v_next_s = 10'd0;
    else if (line_wrap_s) v_next_s = v_cnt_r + 10'd1;
    else                  v_next_s = v_cnt_r;

    h_state_next_s = h_decode(h_next_s);
  end

  // Output decode from the current phase and vertical count.
  always_comb begin
    case (h_state_r)
      H_SYNCP: hsync_s = SYNC_POL;
      default: hsync_s = ~SYNC_POL;
    endcase
    if (({1'b0, v_cnt_r} >= V_SYNC_START) && ({1'b0, v_cnt_r} < V_SYNC_END)) vsync_s = SYNC_POL;
    else                                                                   vsync_s = ~SYNC_POL;
    video_s = (h_state_r == H_ACT) && ({1'b0, v_cnt_r} < V_ACT_END);
  end

  // Registered outputs; level outputs only advance while enabled so they freeze with the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_tick <= 1'b0;
      line_end   <= 1'b0;
      frame_end  <= 1'b0;
      video_on   <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      pixel_x    <= 10'd0;
      pixel_y    <= 10'd0;
    end else begin
      pixel_tick <= tick_s;
      line_end   <= line_wrap_s;
      frame_end  <= frame_wrap_s;
      if (enable) begin
        pixel_x  <= h_cnt_r;
        pixel_y  <= v_cnt_r;
        hsync    <= hsync_s;
        vsync    <= vsync_s;
        video_on <= video_s;
      end
    end
  end

endmodule
